vx_fpu_dispatch_rr: RTL and testbench
=====================================

Name: vx_fpu_dispatch_rr

Overview:
- Parametrised dispatch/collect stage between the FPU issue port and NUM_UNITS independent FP sub-units (FMA, DIV, SQRT, CVT, NCP, ...).
- Steers the issue handshake to the unit named by unit_sel and limits each unit to MAX_INFLIGHT outstanding ops using per-unit credit counters.
- Merges unit responses onto one output port with a round-robin arbiter, replacing fixed-priority selection.
- Has an optional registered skid-buffer output stage.

Parameters:
- NUM_UNITS, 5: number of attached sub-units (2..16).
- LANES, 4: SIMD lanes per result.
- DATAW, 32: bits per lane result.
- TAGW, 4: tag width.
- MAX_INFLIGHT, 4: outstanding-op cap per unit (1..255).
- OUT_REG, 1: 0 = combinational output; 1 = 2-entry skid buffer.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  issue request valid.
- ready_in  out  1  issue accepted when valid_in && ready_in.
- unit_sel  in  SELW=clog2(NUM_UNITS)  target unit.
- unit_valid_in  out  NUM_UNITS  per-unit issue valid.
- unit_ready_in  in  NUM_UNITS  per-unit issue ready.
- unit_valid_out  in  NUM_UNITS  per-unit response valid.
- unit_ready_out  out  NUM_UNITS  per-unit response ready.
- unit_result  in  NUM_UNITS*LANES*DATAW  per-unit results.
- unit_has_fflags  in  NUM_UNITS  per-unit fflags-valid.
- unit_fflags  in  NUM_UNITS*LANES*5  per-unit fflags.
- unit_tag_out  in  NUM_UNITS*TAGW  per-unit tags.
- valid_out  out  1  merged response valid.
- ready_out  in  1  downstream ready.
- result  out  LANES*DATAW  merged result.
- has_fflags  out  1  merged fflags-valid.
- fflags  out  LANES*5  merged fflags.
- tag_out  out  TAGW  merged tag.
- sel_err  out  1  pulse: illegal unit_sel presented.
- idle  out  1  all credits free and output stage empty.

Behaviour:
Dispatch (combinational):
- credit_ok[i] = cnt[i] < MAX_INFLIGHT.
- unit_valid_in[i] = valid_in && unit_sel==i && credit_ok[i].
- ready_in = unit_ready_in[unit_sel] && credit_ok[unit_sel].
- unit_sel >= NUM_UNITS: no unit_valid_in, ready_in=0, sel_err = valid_in.

Credit counters:
- cnt[i] has width clog2(MAX_INFLIGHT+1); reset value 0.
- +1 on issue fire to unit i; -1 on response fire from unit i; both in the same cycle leaves cnt unchanged.
- Decrement at 0 saturates at 0 (never underflows).
- While cnt[i]==MAX_INFLIGHT, unit i issues stall; other units continue to issue.

Arbiter:
- Round-robin over unit_valid_out with rr_ptr = highest-priority index; reset rr_ptr=0.
- Grant g = first valid at or after rr_ptr, wrapping modulo NUM_UNITS.
- unit_ready_out[g] = acc (output-stage accept); all other unit_ready_out bits are 0.
- On fire, rr_ptr <= (g+1) mod NUM_UNITS. No fire leaves rr_ptr unchanged, so grant g stays stable under backpressure.
- A granted unit's valid/data must not change until it fires.

Output stage:
- OUT_REG=0: valid_out = |unit_valid_out; outputs mux the granted unit; acc = ready_out; latency 0.
- OUT_REG=1: 2-entry skid buffer; acc = !full (registered, no combinational path from ready_out); latency 1 cycle; sustains 1 response/cycle.
- OUT_REG=1, reset: valid_out=0; result/fflags/tag_out/has_fflags=0.
- OUT_REG=1, empty+push: entry visible next cycle.
- OUT_REG=1, full: acc=0, which stalls all units.
- OUT_REG=1, push+pop same cycle: occupancy unchanged, order preserved.

Other:
- idle = (all cnt==0) && output stage empty.
- Reset mid-operation: counters, rr_ptr and buffer clear immediately (async); in-flight ops are dropped and the units must be reset together with this block.

Test Plan:
- NUM_UNITS=5, MAX_INFLIGHT=2, unit 1 never responds; issue sel=1 three times -> first two fire, third sees ready_in=0. Issue sel=0 while unit 1 is stalled -> accepted.
- Units 0, 2, 4 hold valid_out continuously, ready_out=1, OUT_REG=1 -> output tags appear in order 0,2,4,0,2,4 starting one cycle after the first grant; no starvation.
- ready_out=0 for 5 cycles with units 0 and 3 valid -> exactly 2 responses buffered; unit_ready_out=0 afterwards; release -> both drain in grant order, then arbitration resumes.
- Same cycle: issue fire to unit 2 and response fire from unit 2 with cnt=1 -> cnt stays 1. Response from a unit with cnt=0 -> cnt stays 0.
- unit_sel=6 with valid_in=1 (NUM_UNITS=5) -> sel_err=1, ready_in=0, unit_valid_in=0.
- Assert reset mid-traffic with buffer full and cnt=2 -> next edge: valid_out=0, idle=1, rr_ptr=0.

Source files
------------

// File: rtl/vx_fpu_dispatch_rr.sv
// FPU dispatch/collect stage: credit-limited issue steering to NUM_UNITS sub-units and a
// round-robin merge of their responses onto one port, optionally through a 2-entry skid buffer.
module vx_fpu_dispatch_rr #(
   parameter int  NUM_UNITS    = 5,
   parameter int  LANES        = 4,
   parameter int  DATAW        = 32,
   parameter int  TAGW         = 4,
   parameter int  MAX_INFLIGHT = 4,
   parameter int  OUT_REG      = 1,
   localparam int SELW         = $clog2(NUM_UNITS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            valid_in,
   output logic                            ready_in,
   input  logic [SELW-1:0]                 unit_sel,
   output logic [NUM_UNITS-1:0]            unit_valid_in,
   input  logic [NUM_UNITS-1:0]            unit_ready_in,
   input  logic [NUM_UNITS-1:0]            unit_valid_out,
   output logic [NUM_UNITS-1:0]            unit_ready_out,
   input  logic [NUM_UNITS*LANES*DATAW-1:0] unit_result,
   input  logic [NUM_UNITS-1:0]            unit_has_fflags,
   input  logic [NUM_UNITS*LANES*5-1:0]    unit_fflags,
   input  logic [NUM_UNITS*TAGW-1:0]       unit_tag_out,
   output logic                            valid_out,
   input  logic                            ready_out,
   output logic [LANES*DATAW-1:0]          result,
   output logic                            has_fflags,
   output logic [LANES*5-1:0]              fflags,
   output logic [TAGW-1:0]                 tag_out,
   output logic                            sel_err,
   output logic                            idle
);

   // Every port pair is valid/ready: a transfer happens on a cycle where both are high;
   // ready may depend on valid, and a source holds valid and data stable until it transfers.

   localparam int                RW      = LANES * DATAW;
   localparam int                FW      = LANES * 5;
   localparam int                CNTW    = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNTW-1:0]   MAX_CNT = CNTW'(MAX_INFLIGHT);

   typedef struct packed {
      logic            has_fflags;
      logic [FW-1:0]   fflags;
      logic [TAGW-1:0] tag;
      logic [RW-1:0]   result;
   } entry_t;

   function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_UNITS) s = s - NUM_UNITS;
      return SELW'(s);
   endfunction

   logic                 sel_legal;
   logic [NUM_UNITS-1:0] credit_ok;
   logic [NUM_UNITS-1:0] issue_fire;
   logic [NUM_UNITS-1:0] resp_fire;
   logic [CNTW-1:0]      cnt [NUM_UNITS];
   logic                 all_free;

   logic [SELW-1:0]      rr_ptr;
   logic [SELW-1:0]      grant;
   logic                 any_valid;
   logic                 acc;
   logic                 arb_fire;
   entry_t               sel_ent;
   entry_t               out_ent;
   logic                 stage_empty;

   // Dispatch: an out-of-range select never reaches a unit and is flagged instead.
   assign sel_legal = int'(unit_sel) < NUM_UNITS;
   assign sel_err   = valid_in && !sel_legal;

   always_comb begin
      unit_valid_in = '0;
      ready_in      = 1'b0;
      credit_ok     = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         credit_ok[i] = cnt[i] < MAX_CNT;
         if (sel_legal && int'(unit_sel) == i) begin
            unit_valid_in[i] = valid_in && credit_ok[i];
            ready_in         = unit_ready_in[i] && credit_ok[i];
         end
      end
   end

   assign issue_fire = unit_valid_in & unit_ready_in;
   assign resp_fire  = unit_valid_out & unit_ready_out;

   // Per-unit outstanding-op counters; a stray response at zero is absorbed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_UNITS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (issue_fire[i] && !resp_fire[i]) begin
               cnt[i] <= cnt[i] + CNTW'(1);
            end else if (resp_fire[i] && !issue_fire[i] && cnt[i] != '0) begin
               cnt[i] <= cnt[i] - CNTW'(1);
            end
         end
      end
   end

   always_comb begin
      all_free = 1'b1;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (cnt[i] != '0) all_free = 1'b0;
      end
   end

   // Round-robin grant: scanning from the far end lets the nearest valid unit win.
   always_comb begin
      grant = '0;
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
         if (unit_valid_out[wrap_idx(rr_ptr, k)]) grant = wrap_idx(rr_ptr, k);
      end
   end

   assign any_valid = |unit_valid_out;
   assign arb_fire  = any_valid && acc;

   always_comb begin
      unit_ready_out        = '0;
      unit_ready_out[grant] = acc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (arb_fire) begin
         rr_ptr <= wrap_idx(grant, 1);
      end
   end

   always_comb begin
      sel_ent.has_fflags = unit_has_fflags[grant];
      sel_ent.fflags     = unit_fflags[int'(grant)*FW +: FW];
      sel_ent.tag        = unit_tag_out[int'(grant)*TAGW +: TAGW];
      sel_ent.result     = unit_result[int'(grant)*RW +: RW];
   end

   generate
      if (OUT_REG != 0) begin : g_skid
         entry_t     mem [2];
         logic       rd_ptr;
         logic       wr_ptr;
         logic [1:0] count;
         logic       push;
         logic       pop;

         // Accept depends only on registered occupancy, cutting the ready_out timing path.
         assign acc         = count != 2'd2;
         assign push        = arb_fire;
         assign pop         = (count != 2'd0) && ready_out;
         assign valid_out   = count != 2'd0;
         assign stage_empty = count == 2'd0;
         assign out_ent     = (count != 2'd0) ? mem[rd_ptr] : '0;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               mem[0] <= '0;
               mem[1] <= '0;
               rd_ptr <= 1'b0;
               wr_ptr <= 1'b0;
               count  <= 2'd0;
            end else begin
               if (push) begin
                  mem[wr_ptr] <= sel_ent;
                  wr_ptr      <= !wr_ptr;
               end
               if (pop) rd_ptr <= !rd_ptr;
               case ({push, pop})
                  2'b10:   count <= count + 2'd1;
                  2'b01:   count <= count - 2'd1;
                  default: count <= count;
               endcase
            end
         end
      end else begin : g_comb
         assign acc         = ready_out;
         assign valid_out   = any_valid;
         assign stage_empty = 1'b1;
         assign out_ent     = sel_ent;
      end
   endgenerate

   assign result     = out_ent.result;
   assign has_fflags = out_ent.has_fflags;
   assign fflags     = out_ent.fflags;
   assign tag_out    = out_ent.tag;
   assign idle       = all_free && stage_empty;

   a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(unit_ready_out));

   generate
      for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_cnt_chk
         a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt[gi] <= MAX_CNT);
      end
   endgenerate

endmodule

// File: tb/tb_vx_fpu_dispatch_rr.sv
// Bench for vx_fpu_dispatch_rr: emulated sub-units, a transaction-level reference model
// and a queue scoreboard whose monitor checks every merged response the DUT delivers.
module tb_vx_fpu_dispatch_rr;

   localparam int NU    = 5;
   localparam int LN    = 4;
   localparam int DW    = 32;
   localparam int TW    = 4;
   localparam int MI    = 2;
   localparam int RW    = LN * DW;
   localparam int FW    = LN * 5;
   localparam int ENT_W = 1 + FW + TW + RW;

   logic                clk;
   logic                reset = 1'b0;
   logic                valid_in;
   logic                ready_in;
   logic [2:0]          unit_sel;
   logic [NU-1:0]       unit_valid_in;
   logic [NU-1:0]       unit_ready_in;
   logic [NU-1:0]       unit_valid_out;
   logic [NU-1:0]       unit_ready_out;
   logic [NU*RW-1:0]    unit_result;
   logic [NU-1:0]       unit_has_fflags;
   logic [NU*FW-1:0]    unit_fflags;
   logic [NU*TW-1:0]    unit_tag_out;
   logic                valid_out;
   logic                ready_out;
   logic [RW-1:0]       result;
   logic                has_fflags;
   logic [FW-1:0]       fflags;
   logic [TW-1:0]       tag_out;
   logic                sel_err;
   logic                idle;

   // Emulated sub-units: each presents one response word {has_fflags, fflags, tag, result}.
   logic [NU-1:0]       resp_valid;
   logic [ENT_W-1:0]    resp_data [NU];
   logic [NU-1:0]       hold;
   logic [NU-1:0]       mute;
   logic [NU-1:0]       fired;
   int                  pend [NU];
   int                  resp_prob;

   // Reference model state.
   int                  cnt_m [NU];
   int                  occ;
   int                  ptr;
   logic [ENT_W-1:0]    exp_q [$];
   int                  tag_log [$];

   int                  checks;
   int                  errors;

   vx_fpu_dispatch_rr #(
      .NUM_UNITS(NU), .LANES(LN), .DATAW(DW), .TAGW(TW), .MAX_INFLIGHT(MI), .OUT_REG(1)
   ) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .unit_sel(unit_sel),
      .unit_valid_in(unit_valid_in), .unit_ready_in(unit_ready_in),
      .unit_valid_out(unit_valid_out), .unit_ready_out(unit_ready_out),
      .unit_result(unit_result), .unit_has_fflags(unit_has_fflags), .unit_fflags(unit_fflags),
      .unit_tag_out(unit_tag_out), .valid_out(valid_out), .ready_out(ready_out),
      .result(result), .has_fflags(has_fflags), .fflags(fflags), .tag_out(tag_out),
      .sel_err(sel_err), .idle(idle)
   );

   assign unit_valid_out = resp_valid;
   for (genvar gi = 0; gi < NU; gi++) begin : g_units
      assign unit_result[gi*RW +: RW]  = resp_data[gi][RW-1:0];
      assign unit_tag_out[gi*TW +: TW] = resp_data[gi][RW +: TW];
      assign unit_fflags[gi*FW +: FW]  = resp_data[gi][RW+TW +: FW];
      assign unit_has_fflags[gi]       = resp_data[gi][ENT_W-1];
   end

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [ENT_W-1:0] got, input logic [ENT_W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, got, want);
      end
   endtask

   function automatic logic [ENT_W-1:0] new_resp(input int u);
      logic [RW-1:0] r;
      logic [FW-1:0] f;
      logic          h;
      for (int k = 0; k < RW / 32; k++) r[k*32 +: 32] = $urandom();
      f = FW'($urandom());
      h = 1'($urandom_range(0, 1));
      return {h, f, TW'(u), r};
   endfunction

   // Called just after a rising edge: retire responses that transferred, maybe present new ones.
   task automatic emulate_units();
      for (int i = 0; i < NU; i++) begin
         if (fired[i]) begin
            resp_valid[i] = 1'b0;
            if (pend[i] > 0) pend[i]--;
         end
         fired[i] = 1'b0;
         if (!resp_valid[i]) begin
            if (hold[i] || (pend[i] > 0 && !mute[i] && $urandom_range(0, 99) < resp_prob)) begin
               resp_valid[i] = 1'b1;
               resp_data[i]  = new_resp(i);
            end
         end
      end
   endtask

   // Reference model: evaluated on the falling edge for the transfers of the coming rising edge.
   task automatic model_cycle();
      logic [NU-1:0] exp_uvi;
      logic [NU-1:0] exp_grant;
      logic          legal, exp_rdy, any, acc, rfire, ifire, pop, inc, dec;
      int            s, g, tot;
      tot = 0;
      for (int i = 0; i < NU; i++) tot += cnt_m[i];
      check("valid_out", valid_out, occ > 0);
      check("idle", idle, tot == 0 && occ == 0);
      s       = int'(unit_sel);
      legal   = s < NU;
      exp_rdy = 1'b0;
      exp_uvi = '0;
      if (legal) begin
         exp_rdy    = unit_ready_in[s] && cnt_m[s] < MI;
         exp_uvi[s] = valid_in && cnt_m[s] < MI;
      end
      check("ready_in", ready_in, exp_rdy);
      check("unit_valid_in", unit_valid_in, exp_uvi);
      check("sel_err", sel_err, valid_in && !legal);
      any = |resp_valid;
      g   = 0;
      for (int k = NU - 1; k >= 0; k--) begin
         if (resp_valid[(ptr + k) % NU]) g = (ptr + k) % NU;
      end
      acc       = occ < 2;
      rfire     = any && acc;
      exp_grant = '0;
      if (rfire) exp_grant[g] = 1'b1;
      check("grant", unit_ready_out & resp_valid, exp_grant);
      pop   = occ > 0 && ready_out;
      ifire = valid_in && exp_rdy;
      if (rfire) begin
         exp_q.push_back(resp_data[g]);
         fired[g] = 1'b1;
         ptr      = (g + 1) % NU;
      end
      occ = occ + (rfire ? 1 : 0) - (pop ? 1 : 0);
      for (int i = 0; i < NU; i++) begin
         inc = ifire && s == i;
         dec = rfire && g == i;
         if (inc && !dec) cnt_m[i]++;
         else if (dec && !inc && cnt_m[i] > 0) cnt_m[i]--;
      end
      if (ifire) pend[s]++;
   endtask

   task automatic step();
      @(negedge clk);
      if (!reset) model_cycle();
      @(posedge clk);
      #1;
      emulate_units();
   endtask

   // Asserted between edges; the clear is asynchronous so outputs are checked at once.
   task automatic apply_reset();
      reset      = 1'b1;
      resp_valid = '0;
      #1;
      check("rst_valid_out", valid_out, 1'b0);
      check("rst_idle", idle, 1'b1);
      check("rst_result", {has_fflags, fflags, tag_out, result}, '0);
      for (int i = 0; i < NU; i++) begin
         cnt_m[i] = 0;
         pend[i]  = 0;
      end
      fired = '0;
      occ   = 0;
      ptr   = 0;
      exp_q.delete();
      tag_log.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!reset && valid_out && ready_out) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: actual tag=%0h required no response", tag_out);
         end else begin
            logic [ENT_W-1:0] want;
            want = exp_q.pop_front();
            if ({has_fflags, fflags, tag_out, result} !== want) begin
               errors++;
               $display("FAIL out_data: actual=%0h required=%0h",
                        {has_fflags, fflags, tag_out, result}, want);
            end
         end
         tag_log.push_back(int'(tag_out));
      end
   end

   initial begin
      checks        = 0;
      errors        = 0;
      valid_in      = 1'b0;
      unit_sel      = '0;
      unit_ready_in = '1;
      ready_out     = 1'b1;
      resp_valid    = '0;
      hold          = '0;
      mute          = '0;
      fired         = '0;
      resp_prob     = 0;
      for (int i = 0; i < NU; i++) begin
         resp_data[i] = '0;
         pend[i]      = 0;
         cnt_m[i]     = 0;
      end
      occ = 0;
      ptr = 0;
      @(posedge clk);
      #1;
      apply_reset();

      // Credit cap: unit 1 never answers, third issue stalls, unit 0 still issues.
      mute     = 5'b00010;
      valid_in = 1'b1;
      unit_sel = 3'd1;
      step();
      step();
      #1;
      check("credit_stall", ready_in, 1'b0);
      step();
      unit_sel = 3'd0;
      #1;
      check("other_unit_issue", ready_in, 1'b1);
      step();

      // Illegal select.
      unit_sel = 3'd6;
      #1;
      check("illegal_sel_err", sel_err, 1'b1);
      check("illegal_ready", ready_in, 1'b0);
      check("illegal_uvi", unit_valid_in, '0);
      step();
      valid_in = 1'b0;
      step();

      // Same-cycle issue and response keep the count; a response at zero saturates.
      apply_reset();
      mute     = '0;
      valid_in = 1'b1;
      unit_sel = 3'd2;
      step();
      resp_valid[2] = 1'b1;
      resp_data[2]  = new_resp(2);
      step();
      step();
      #1;
      check("same_cycle_hold", ready_in, 1'b0);
      valid_in      = 1'b0;
      resp_valid[3] = 1'b1;
      resp_data[3]  = new_resp(3);
      step();
      valid_in = 1'b1;
      unit_sel = 3'd3;
      step();
      step();
      #1;
      check("sat_at_zero", ready_in, 1'b0);
      valid_in = 1'b0;

      // Round-robin fairness over units 0, 2, 4.
      apply_reset();
      hold = 5'b10101;
      emulate_units();
      repeat (8) step();
      check("rr_count", tag_log.size() >= 6, 1'b1);
      for (int k = 0; k < 6 && k < tag_log.size(); k++) check("rr_order", tag_log[k], (2 * k) % 6);
      hold = '0;
      repeat (4) step();

      // Backpressure: two responses buffered, then drained in grant order.
      apply_reset();
      hold      = 5'b01001;
      ready_out = 1'b0;
      emulate_units();
      repeat (5) step();
      check("bp_ready_out", unit_ready_out, '0);
      check("bp_valid_out", valid_out, 1'b1);
      tag_log.delete();
      ready_out = 1'b1;
      repeat (6) step();
      check("bp_count", tag_log.size() >= 4, 1'b1);
      for (int k = 0; k < 4 && k < tag_log.size(); k++) check("bp_order", tag_log[k], (k % 2) * 3);
      hold = '0;
      repeat (4) step();

      // Reset with the buffer full and a unit at its credit cap.
      apply_reset();
      mute     = 5'b00010;
      valid_in = 1'b1;
      unit_sel = 3'd1;
      step();
      step();
      valid_in  = 1'b0;
      ready_out = 1'b0;
      hold      = 5'b01001;
      emulate_units();
      repeat (3) step();
      check("pre_rst_full", unit_ready_out, '0);
      hold = 5'b10001;
      apply_reset();
      emulate_units();
      ready_out = 1'b1;
      repeat (4) step();
      check("rst_ptr_count", tag_log.size() >= 1, 1'b1);
      if (tag_log.size() >= 1) check("rst_ptr_first", tag_log[0], 0);
      hold = '0;
      mute = '0;
      repeat (4) step();

      // Randomized traffic.
      apply_reset();
      resp_prob = 40;
      for (int c = 0; c < 1500; c++) begin
         valid_in      = 1'($urandom_range(0, 1));
         unit_sel      = 3'($urandom_range(0, 7));
         unit_ready_in = NU'($urandom());
         ready_out     = $urandom_range(0, 3) != 0;
         step();
      end

      // Drain.
      valid_in  = 1'b0;
      ready_out = 1'b1;
      resp_prob = 100;
      repeat (60) step();
      check("drain_empty", exp_q.size(), 0);
      check("final_idle", idle, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
